// File: rtl/jt6295_cengen.sv
// Sample-rate clock-enable generator: prescaler + slot counter producing a per-sample strobe
// and SUB sub-phase strobes with half-step twins. Optional resync port: JT6295_CENGEN_SYNC_EN.
module jt6295_cengen #(
    parameter int PRE_HI = 4,
    parameter int PRE_LO = 5,
    parameter int SLOTS  = 33,
    parameter int SUB    = 4,
    parameter int STEP   = 8,
    parameter int PW     = 3,
    parameter int SW     = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cen,
    input  logic           ss,
`ifdef JT6295_CENGEN_SYNC_EN
    input  logic           sync,
`endif
    output logic           cen_sr,
    output logic [SUB-1:0] cen_sub,
    output logic [SUB-1:0] cen_subb,
    output logic [SW-1:0]  slot,
    output logic           ss_act
);

    localparam logic [PW-1:0] LIM_HI    = PW'(PRE_HI - 1);
    localparam logic [PW-1:0] LIM_LO    = PW'(PRE_LO - 1);
    localparam logic [PW-1:0] PRE_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0] PRE_ONE   = PW'(1);
    localparam logic [SW-1:0] SLOT_ZERO = {SW{1'b0}};
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);

    logic [PW-1:0]  pre_r;
    logic [SW-1:0]  slot_r;
    logic           ss_l_r;

    logic           sync_s;
    logic           boundary_s;
    logic           sel_s;
    logic [PW-1:0]  lim_s;
    logic [PW-1:0]  pre_nx_s;
    logic [SW-1:0]  slot_nx_s;
    logic           ss_l_nx_s;
    logic           sr_nx_s;
    logic [SUB-1:0] sub_nx_s;
    logic [SUB-1:0] subb_nx_s;
    logic [SW-1:0]  slot_out_nx_s;

`ifdef JT6295_CENGEN_SYNC_EN
    assign sync_s = sync;
`else
    assign sync_s = 1'b0;
`endif

    // Next-state counters, latched rate and strobe decode from the pre-update counter values
    always_comb begin
        boundary_s    = (pre_r == PRE_ZERO) && (slot_r == SLOT_ZERO);
        // The rate only switches on a boundary tick, so no sample is ever cut short or stretched
        sel_s         = boundary_s ? ss : ss_l_r;
        lim_s         = sel_s ? LIM_HI : LIM_LO;
        pre_nx_s      = pre_r;
        slot_nx_s     = slot_r;
        ss_l_nx_s     = ss_l_r;
        sr_nx_s       = 1'b0;
        sub_nx_s      = {SUB{1'b0}};
        subb_nx_s     = {SUB{1'b0}};
        slot_out_nx_s = slot;
        if (cen) begin
            slot_out_nx_s = slot_r;
            if (sync_s) begin
                pre_nx_s  = PRE_ZERO;
                slot_nx_s = SLOT_ZERO;
            end else begin
                if (boundary_s) begin
                    ss_l_nx_s = ss;
                end else begin
                    ss_l_nx_s = ss_l_r;
                end
                if (pre_r == lim_s) begin
                    pre_nx_s  = PRE_ZERO;
                    slot_nx_s = (slot_r == SLOT_LAST) ? SLOT_ZERO : slot_r + SLOT_ONE;
                end else begin
                    pre_nx_s  = pre_r + PRE_ONE;
                    slot_nx_s = slot_r;
                end
                if (pre_r == PRE_ZERO) begin
                    sr_nx_s = (slot_r == SLOT_ZERO);
                    for (int k = 0; k < SUB; k++) begin
                        sub_nx_s[k]  = (slot_r == SW'(k * STEP));
                        subb_nx_s[k] = (slot_r == SW'(k * STEP + STEP / 2));
                    end
                end else begin
                    sr_nx_s = 1'b0;
                end
            end
        end else begin
            slot_out_nx_s = slot;
        end
    end

    // State and registered outputs; strobes self-clear because the decode defaults to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r    <= PRE_ZERO;
            slot_r   <= SLOT_ZERO;
            ss_l_r   <= 1'b0;
            cen_sr   <= 1'b0;
            cen_sub  <= {SUB{1'b0}};
            cen_subb <= {SUB{1'b0}};
            slot     <= SLOT_ZERO;
        end else begin
            pre_r    <= pre_nx_s;
            slot_r   <= slot_nx_s;
            ss_l_r   <= ss_l_nx_s;
            cen_sr   <= sr_nx_s;
            cen_sub  <= sub_nx_s;
            cen_subb <= subb_nx_s;
            slot     <= slot_out_nx_s;
        end
    end

    assign ss_act = ss_l_r;

endmodule
